// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one SPI A2D converter between N_REQ requesters.
// One conversion at a time, channel held for its duration, watchdog abort on a lost completion.
module a2d_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 2048,
  parameter int TMR_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_chnnl,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [11:0]        res,
  output logic               err,
  output logic               busy,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [11:0]        A2D_res
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_CMPLT, DONE} state_t;

  state_t             state, nxt_state;
  logic [OW-1:0]      owner, ptr, winner;
  logic [2:0]         win_chnnl;
  logic               found;
  logic [2*N_REQ-1:0] rot_req;
  logic [TMR_W-1:0]   wdog;
  logic               wdog_zero;

  assign wdog_zero = (wdog == '0);

  // Rotate so bit 0 is the pointer position; first set bit wins.
  always_comb begin
    rot_req = {req, req} >> ptr;
    found   = 1'b0;
    winner  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_req[k]) begin
        found  = 1'b1;
        winner = OW'((int'(ptr) + k) % N_REQ);
      end
    end
    win_chnnl = '0;
    for (int i = 0; i < N_REQ; i++)
      if (winner == OW'(i)) win_chnnl = req_chnnl[3*i +: 3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:       if (found) nxt_state = START;
      START:      nxt_state = WAIT_CMPLT;
      WAIT_CMPLT: if (cnv_cmplt || wdog_zero) nxt_state = DONE;
      DONE:       nxt_state = IDLE;
      default:    nxt_state = IDLE;
    endcase
  end

  // Watchdog is loaded on grant so it reads TIMEOUT-1 during START; abort lands
  // exactly TIMEOUT cycles after the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      ptr   <= '0;
      chnnl <= '0;
      wdog  <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner <= winner;
          chnnl <= win_chnnl;
          wdog  <= TMR_W'(TIMEOUT - 1);
        end
        START: wdog <= wdog - 1'b1;
        WAIT_CMPLT: begin
          if (cnv_cmplt) begin
            res <= A2D_res;
            err <= 1'b0;
          end else if (wdog_zero) begin
            err <= 1'b1;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        DONE: ptr <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    strt_cnv = (state == START);
    gnt      = '0;
    done     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i]  = busy && (owner == OW'(i));
      done[i] = (state == DONE) && (owner == OW'(i));
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Bench for a2d_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_a2d_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [3*N-1:0]    req_chnnl = '0;
  logic              cnv_cmplt = 1'b0;
  logic [11:0]       A2D_res = '0;
  logic [N-1:0]      gnt, done;
  logic [11:0]       res;
  logic              err, busy, strt_cnv;
  logic [2:0]        chnnl;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: owner (-1 when idle), age = cycles since grant, done flag for the current cycle.
  int          m_own = -1;
  int          m_age = 0;
  int          m_ptr = 0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [11:0] m_res = '0;
  logic [2:0]  m_chnnl = '0;

  a2d_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TMR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .gnt(gnt), .done(done), .res(res), .err(err), .busy(busy),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_own = -1; m_age = 0; m_ptr = 0; m_done = 1'b0;
    m_err = 1'b0; m_res = '0; m_chnnl = '0;
  endtask

  task automatic model_step();
    bit hit;
    if (!rst_n) return;
    if (m_done) begin
      m_done = 1'b0;
      m_ptr  = (m_own + 1) % N;
      m_own  = -1;
    end else if (m_own < 0) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!hit && req[c]) begin
          hit = 1'b1; m_own = c; m_age = 0; m_chnnl = req_chnnl[3*c +: 3];
        end
      end
    end else if (m_age > 0 && cnv_cmplt) begin
      m_res = A2D_res; m_err = 1'b0; m_done = 1'b1;
    end else if (m_age == TO - 1) begin
      m_err = 1'b1; m_done = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  task automatic cmp_cycle();
    logic [N-1:0] eg, ed;
    logic         eb, es;
    eg = (m_own >= 0) ? N'(1 << m_own) : '0;
    ed = m_done ? eg : '0;
    eb = (m_own >= 0);
    es = (m_own >= 0) && (m_age == 0) && !m_done;
    n_vec++;
    if ({gnt, done, res, err, busy, strt_cnv, chnnl} !== {eg, ed, m_res, m_err, eb, es, m_chnnl}) begin
      n_bad++;
      $display("FAIL cycle %0d: gnt=%b done=%b res=%h err=%b busy=%b strt=%b chnnl=%0d, want gnt=%b done=%b res=%h err=%b busy=%b strt=%b chnnl=%0d",
               cyc, gnt, done, res, err, busy, strt_cnv, chnnl, eg, ed, m_res, m_err, eb, es, m_chnnl);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_strt();
    int n;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 40) begin tick(); n++; end
    chk("wait strt_cnv", 32'(strt_cnv), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done === '0 && n < 40) begin tick(); n++; end
    chk("wait done", 32'(done != '0), 32'd1);
  endtask

  initial begin
    logic [2:0]   chs [3];
    logic [N-1:0] oh;
    int           s;
    chs[0] = 3'd1; chs[1] = 3'd0; chs[2] = 3'd7;
    model_reset();
    tick();
    do_reset();
    tick();
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset res/err/chnnl", 32'({res, err, chnnl}), 32'd0);

    // single request
    req_chnnl = {3'd0, 3'd0, 3'd4};
    req = 3'b001;
    tick();
    chk("single gnt", 32'(gnt), 32'b001);
    chk("single chnnl", 32'(chnnl), 32'd4);
    chk("single strt", 32'(strt_cnv), 32'd1);
    repeat (10) tick();
    cnv_cmplt = 1'b1; A2D_res = 12'hA5C;
    tick();
    cnv_cmplt = 1'b0; req = '0;
    chk("single done", 32'(done), 32'b001);
    chk("single res", 32'(res), 32'hA5C);
    chk("single err", 32'(err), 32'd0);
    tick();

    // contention: grant order 0,1,2,0,1,2
    do_reset();
    req_chnnl = {3'd7, 3'd0, 3'd1};
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_strt();
      oh = N'(1) << (k % 3);
      chk("rr gnt", 32'(gnt), 32'(oh));
      chk("rr chnnl", 32'(chnnl), 32'(chs[k % 3]));
      tick();
      cnv_cmplt = 1'b1; A2D_res = 12'h100 + 12'(k);
      tick();
      cnv_cmplt = 1'b0;
      chk("rr done", 32'(done), 32'(oh));
      if (k == 5) req = '0;
    end
    tick();

    // timeout: res keeps 0x105 from the last contention conversion
    A2D_res = 12'h0F0;
    req_chnnl = {3'd5, 3'd0, 3'd0};
    req = 3'b100;
    wait_strt();
    s = cyc;
    wait_done();
    req = '0;
    chk("timeout latency", 32'(cyc - s), 32'd16);
    chk("timeout done", 32'(done), 32'b100);
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout res held", 32'(res), 32'h105);
    tick();
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    repeat (4) begin
      tick();
      chk("late cmplt no done", 32'({done, busy}), 32'd0);
    end

    // race: completion in the watchdog's last cycle
    req_chnnl = {3'd0, 3'd3, 3'd0};
    req = 3'b010;
    wait_strt();
    s = cyc;
    repeat (15) tick();
    cnv_cmplt = 1'b1; A2D_res = 12'h3C3;
    tick();
    cnv_cmplt = 1'b0; req = '0;
    chk("race latency", 32'(cyc - s), 32'd16);
    chk("race done", 32'(done), 32'b010);
    chk("race err", 32'(err), 32'd0);
    chk("race res", 32'(res), 32'h3C3);
    tick();

    // mid-conversion changes are ignored
    req_chnnl = {3'd7, 3'd3, 3'd2};
    req = 3'b001;
    wait_strt();
    tick();
    req_chnnl[2:0] = 3'd6; req = '0;
    repeat (3) begin
      tick();
      chk("midop chnnl", 32'(chnnl), 32'd2);
      chk("midop gnt", 32'(gnt), 32'b001);
    end
    cnv_cmplt = 1'b1; A2D_res = 12'h777;
    tick();
    cnv_cmplt = 1'b0;
    chk("midop done", 32'(done), 32'b001);
    chk("midop res", 32'(res), 32'h777);
    tick();

    // async reset mid-conversion
    req_chnnl = {3'd0, 3'd1, 3'd5};
    req = 3'b001;
    wait_strt();
    tick(); tick();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst outputs", 32'({gnt, done, res, err, busy, strt_cnv, chnnl}), 32'd0);
    req = 3'b010;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset gnt", 32'(gnt), 32'b010);
    chk("post-reset chnnl", 32'(chnnl), 32'd1);
    tick();
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0; req = '0;
    tick();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            req_chnnl[3*i +: 3] = 3'($urandom);
          end
        end else if (gnt[i]) begin
          if ($urandom_range(7) == 0) req_chnnl[3*i +: 3] = 3'($urandom);
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end
      end
      cnv_cmplt = ($urandom_range(11) == 0);
      A2D_res   = 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/a2d_arbiter.md
Name: a2d_arbiter

Overview:
- Shares the single SPI A2D converter (strt_cnv/chnnl/cnv_cmplt/A2D_res) between N_REQ requesters: motion controller IR sampling, battery monitor, diagnostic readback.
- Round-robin arbitration, one conversion at a time. Channel is held stable for the whole conversion. Result and a completion pulse are returned to the owner.
- A watchdog aborts a conversion that never completes.

Parameters:
N_REQ, 3, number of requesters (2..8)
TIMEOUT, 2048, cycles from strt_cnv to forced abort if no cnv_cmplt
TMR_W, 12, watchdog counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req  input  N_REQ  level request per requester, held until its done pulse
req_chnnl  input  3*N_REQ  requested channel; requester i uses bits [3i+2:3i]
gnt  output  N_REQ  one-hot owner, high from grant through DONE; 0 when idle
done  output  N_REQ  one-cycle pulse to owner when res/err valid
res  output  12  last conversion result, held until next completion
err  output  1  qualifies done: 1 = timed out, res unchanged
busy  output  1  high in any state other than IDLE
strt_cnv  output  1  one-cycle start pulse to A2D
chnnl  output  3  channel to A2D, registered
cnv_cmplt  input  1  A2D conversion complete pulse
A2D_res  input  12  A2D result, valid with cnv_cmplt

Behaviour:
- Reset: state IDLE, round-robin pointer ptr=0. gnt, done, res, err, busy, strt_cnv and chnnl are all 0.
- States: IDLE, START, WAIT_CMPLT, DONE. Outputs are Moore-decoded from registered state/owner. The exceptions are res and err, which are registered.
- IDLE:
  - if req != 0, select the first set bit scanning ptr, ptr+1, … wrapping modulo N_REQ.
  - Register owner <= winner, gnt <= onehot(winner), chnnl <= req_chnnl[winner]; go to START.
  - If req == 0, stay in IDLE.
- START: strt_cnv=1 for exactly this cycle. Watchdog loads TIMEOUT-1. Go to WAIT_CMPLT.
- WAIT_CMPLT:
  - cnv_cmplt=1 → res <= A2D_res, err <= 0, go to DONE.
  - Else if watchdog == 0 → err <= 1, res unchanged, go to DONE.
  - Else decrement watchdog.
  - If cnv_cmplt and watchdog==0 occur in the same cycle, cnv_cmplt wins (err=0).
- DONE: done[owner]=1 for one cycle. ptr <= (owner+1) mod N_REQ. Go to IDLE; gnt clears on entering IDLE.
- chnnl changes only on grant; it is stable from START through DONE and held while idle.
- Latency: req sampled in IDLE at cycle 0 → gnt and chnnl at cycle 1 with strt_cnv=1 → done at cycle k+1 when cnv_cmplt is sampled at cycle k. Minimum req-to-done is 3 cycles.
- Requester drops req the cycle after done. If it keeps req high, that is a new request. It is arbitrated after the other pending requesters because ptr has advanced.
- Changes to req_chnnl or req after grant are ignored until DONE. Dropping req mid-conversion does not abort; done is still pulsed.
- cnv_cmplt outside WAIT_CMPLT is ignored (stray or late completion after a timeout).
- Minimum one IDLE cycle between conversions: back-to-back grants are 1 cycle apart after DONE.
- Async reset mid-conversion returns everything to reset values immediately. No done is issued.

Test Plan:
- Single request: req=3'b001, chnnl0=3'h4, cnv_cmplt 10 cycles after strt_cnv with A2D_res=12'hA5C → gnt=001 and chnnl=4 during conversion; done=001 one cycle after cnv_cmplt; res=A5C; err=0; single strt_cnv pulse.
- Contention: req=3'b111 held continuously, channels 1/0/7 → grant order 0,1,2,0,…; chnnl follows 1,0,7; no requester starves.
- Timeout: TIMEOUT=16, cnv_cmplt never arrives → done exactly 16 cycles after strt_cnv with err=1 and res unchanged. A late cnv_cmplt is ignored and no second done occurs.
- Race: cnv_cmplt in the same cycle the watchdog reaches 0 → err=0, res captured.
- Mid-operation changes: change req_chnnl[owner] and drop req during WAIT_CMPLT → chnnl unchanged; done still pulsed.
- Reset mid-conversion: assert rst_n=0 in WAIT_CMPLT → all outputs 0 asynchronously. After release, req=3'b010 is granted first (ptr=0 scan finds bit 1).
